axis_byte_packer: RTL and testbench

//  Parametrised AXI-Stream byte packer/realigner for the e1000 datapaths.
//  - Compacts every byte whose tkeep bit is set, in stream order, into full output beats.

---
 rtl/axis_byte_packer_if.sv | 18 +
 rtl/axis_byte_packer.sv | 156 +++++++++++++++
 tb/tb_axis_byte_packer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_byte_packer_if.sv
// AXI-Stream bus bundle used on both sides of axis_byte_packer.
//   tdata  : 8*DATA_BYTES payload
//   tkeep  : DATA_BYTES byte valids
//   tlast  : end of packet
//   tvalid : beat valid (master -> slave)
//   tready : beat accepted (slave -> master)
interface axis_byte_packer_if #(
    parameter int unsigned DATA_BYTES = 4
) ();
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_byte_packer.sv
// AXI-Stream byte packer/realigner.
// Compacts every kept input byte, in stream order, into full output beats and
// optionally inserts a per-packet count of empty leading lanes in the first
// output beat (header alignment).
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   s             : input stream (slave); s.tready is combinational from m.tready
//   s_offset      : leading empty lanes, sampled on the first beat of a packet
//   m             : packed output stream (master); all payload/control registered
module axis_byte_packer #(
    parameter int unsigned DATA_BYTES        = 4,
    parameter string       INPUT_BIG_ENDIAN  = "TRUE",
    parameter string       OUTPUT_BIG_ENDIAN = "TRUE",
    parameter string       OFFSET_EN         = "FALSE",
    localparam int unsigned OFF_W = ($clog2(DATA_BYTES) > 1) ? $clog2(DATA_BYTES) : 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_byte_packer_if.slave     s,
    input  logic [OFF_W-1:0]      s_offset,
    axis_byte_packer_if.master    m
);
    localparam int unsigned BUF_B = 2 * DATA_BYTES;
    localparam int unsigned CW    = $clog2(BUF_B);
    localparam int unsigned PW    = CW + 1;
    localparam bit IN_BE  = (INPUT_BIG_ENDIAN == "TRUE");
    localparam bit OUT_BE = (OUTPUT_BIG_ENDIAN == "TRUE");
    localparam bit OFF_ON = (OFFSET_EN == "TRUE");

    // Lane-indexed byte buffer; invariant: lanes >= cnt are always zero.
    logic [BUF_B-1:0][7:0]      buf_q, buf_n;
    logic [CW-1:0]              cnt_q, cnt_n;
    logic                       tail_q, tail_n;
    logic                       first_q, first_n;
    logic [OFF_W-1:0]           lead_q, lead_n;
    logic                       lead_pend_q, lead_pend_n;
    logic                       valid_q, valid_n;
    logic                       last_q, last_n;
    logic [DATA_BYTES-1:0]      keep_q, keep_n;

    logic [DATA_BYTES-1:0][7:0] in_lane;
    logic [DATA_BYTES-1:0]      in_keep;
    logic [8*DATA_BYTES-1:0]    out_data;
    logic [DATA_BYTES-1:0]      out_keep;
    logic [OFF_W-1:0]           off_c;
    logic                       take;
    logic                       ready_c;
    logic                       acc;
    logic [PW-1:0]              pos;

    // Map bus byte positions to lane order on both sides.
    always_comb begin : lane_map
        in_lane  = '0;
        in_keep  = '0;
        out_data = '0;
        out_keep = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            in_lane[i] = s.tdata[8*(IN_BE ? DATA_BYTES-1-i : i) +: 8];
            in_keep[i] = s.tkeep[IN_BE ? DATA_BYTES-1-i : i];
            out_data[8*(OUT_BE ? DATA_BYTES-1-i : i) +: 8] = buf_q[i];
            out_keep[OUT_BE ? DATA_BYTES-1-i : i]          = keep_q[i];
        end
    end

    assign off_c    = OFF_ON ? s_offset : '0;
    assign take     = valid_q & m.tready;
    assign ready_c  = ~tail_q & ((cnt_q < CW'(DATA_BYTES)) | take);
    assign acc      = s.tvalid & ready_c;

    assign s.tready = ready_c;
    assign m.tdata  = out_data;
    assign m.tkeep  = out_keep;
    assign m.tvalid = valid_q;
    assign m.tlast  = last_q;

    // Shift out the taken beat, then append the accepted beat at the post-shift fill level.
    always_comb begin : next_state
        buf_n       = buf_q;
        cnt_n       = cnt_q;
        tail_n      = tail_q;
        first_n     = first_q;
        lead_n      = lead_q;
        lead_pend_n = lead_pend_q;
        pos         = '0;
        valid_n     = 1'b0;
        last_n      = 1'b0;
        keep_n      = '0;

        if (take) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                buf_n[i]            = buf_q[i + DATA_BYTES];
                buf_n[i + DATA_BYTES] = 8'h00;
            end
            cnt_n       = (cnt_q >= CW'(DATA_BYTES)) ? cnt_q - CW'(DATA_BYTES) : '0;
            lead_pend_n = 1'b0;
            if (last_q) begin
                tail_n = 1'b0;
            end
        end

        if (acc) begin
            pos = PW'(cnt_n);
            // First beat of a packet: reserve the lead lanes (left zero) ahead of the data.
            if (first_q) begin
                pos         = pos + PW'(off_c);
                lead_n      = off_c;
                lead_pend_n = 1'b1;
            end
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (in_keep[i]) begin
                    if (pos < PW'(BUF_B)) begin
                        buf_n[pos[CW-1:0]] = in_lane[i];
                    end
                    pos = pos + PW'(1);
                end
            end
            cnt_n   = pos[CW-1:0];
            first_n = s.tlast;
            // An empty packet ends here; it never owns an output beat.
            if (s.tlast) begin
                tail_n = (cnt_n != '0);
            end
        end

        valid_n = (cnt_n >= CW'(DATA_BYTES)) | (tail_n & (cnt_n != '0));
        last_n  = tail_n & (cnt_n <= CW'(DATA_BYTES));
        for (int i = 0; i < DATA_BYTES; i++) begin
            keep_n[i] = (CW'(i) < cnt_n) & ~(lead_pend_n & (OFF_W'(i) < lead_n));
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin : regs
        if (!aresetn) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            tail_q      <= 1'b0;
            first_q     <= 1'b1;
            lead_q      <= '0;
            lead_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            keep_q      <= '0;
        end else begin
            buf_q       <= buf_n;
            cnt_q       <= cnt_n;
            tail_q      <= tail_n;
            first_q     <= first_n;
            lead_q      <= lead_n;
            lead_pend_q <= lead_pend_n;
            valid_q     <= valid_n;
            last_q      <= last_n;
            keep_q      <= keep_n;
        end
    end
endmodule

// File: tb/tb_axis_byte_packer.sv
// Testbench for axis_byte_packer (DATA_BYTES=4, big-endian, offsets enabled).
module tb_axis_byte_packer;
    logic       aclk = 1'b0;
    logic       aresetn;
    logic [1:0] s_offset;
    bit         rand_mode;

    axis_byte_packer_if #(.DATA_BYTES(4)) s_if ();
    axis_byte_packer_if #(.DATA_BYTES(4)) m_if ();

    axis_byte_packer #(
        .DATA_BYTES(4), .INPUT_BIG_ENDIAN("TRUE"), .OUTPUT_BIG_ENDIAN("TRUE"), .OFFSET_EN("TRUE")
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .s(s_if), .s_offset(s_offset), .m(m_if)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [1:0]  o;
        logic        has;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    localparam int NV = 14;
    vec_t vecs [NV];
    exp_t q [$];
    int   total = 0;
    int   bad = 0;

    logic        held = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_k;
    logic        prev_l;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = {8{k[j]}};
        return r;
    endfunction

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
        e.d = d; e.k = k; e.l = l;
        q.push_back(e);
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] o);
        int   n;
        logic rdy;
        s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_offset = o; s_if.tvalid = 1'b1;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge aclk);
            rdy = s_if.tready;
            @(posedge aclk);
            #1;
            n++;
        end
        s_if.tvalid = 1'b0;
        if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    // Random output backpressure when enabled.
    always @(posedge aclk) begin
        #1;
        if (rand_mode) m_if.tready = 1'($urandom_range(0, 1));
    end

    // Output monitor: held-beat stability and scoreboard compare on each handshake.
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && m_if.tvalid) begin
            if (held) begin
                chk("held_data", m_if.tdata, prev_d);
                chk("held_keep", m_if.tkeep, prev_k);
                chk("held_last", m_if.tlast, prev_l);
            end
            if (m_if.tready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", m_if.tdata, 32'hFFFF_FFFF ^ m_if.tdata);
                end else begin
                    e = q.pop_front();
                    chk("beat_data", m_if.tdata & kmask(e.k), e.d & kmask(e.k));
                    chk("beat_keep", m_if.tkeep, e.k);
                    chk("beat_last", m_if.tlast, e.l);
                end
            end
        end
        held   = aresetn && m_if.tvalid && !m_if.tready;
        prev_d = m_if.tdata;
        prev_k = m_if.tkeep;
        prev_l = m_if.tlast;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {data, keep, last, offset, has_out, exp_data, exp_keep, exp_last}
        vecs[0]  = '{32'h11223344, 4'hF, 1'b0, 2'd0, 1'b1, 32'h11223344, 4'hF, 1'b0};
        vecs[1]  = '{32'h55667788, 4'hF, 1'b0, 2'd0, 1'b1, 32'h55667788, 4'hF, 1'b0};
        vecs[2]  = '{32'h99AABBCC, 4'hF, 1'b1, 2'd0, 1'b1, 32'h99AABBCC, 4'hF, 1'b1};
        vecs[3]  = '{32'hAABBCCDD, 4'hA, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[4]  = '{32'hEEFFA0B0, 4'h5, 1'b1, 2'd0, 1'b1, 32'hAACCFFB0, 4'hF, 1'b1};
        vecs[5]  = '{32'h01020304, 4'hF, 1'b0, 2'd2, 1'b1, 32'h00000102, 4'h3, 1'b0};
        vecs[6]  = '{32'h05060708, 4'hC, 1'b1, 2'd3, 1'b1, 32'h03040506, 4'hF, 1'b1};
        vecs[7]  = '{32'hDEADBEEF, 4'hF, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0};
        vecs[8]  = '{32'h5A000000, 4'h8, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[9]  = '{32'h00000000, 4'h0, 1'b1, 2'd0, 1'b1, 32'h5A000000, 4'h8, 1'b1};
        vecs[10] = '{32'h12345678, 4'h0, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0};
        vecs[11] = '{32'h00000000, 4'h0, 1'b1, 2'd3, 1'b1, 32'h00000000, 4'h0, 1'b1};
        vecs[12] = '{32'hA1B2C3D4, 4'h7, 1'b0, 2'd1, 1'b1, 32'h00B2C3D4, 4'h7, 1'b0};
        vecs[13] = '{32'hE5F60718, 4'h9, 1'b1, 2'd2, 1'b1, 32'hE5180000, 4'hC, 1'b1};

        aresetn = 1'b0; rand_mode = 1'b0; s_offset = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_tvalid", m_if.tvalid, 0);
        chk("reset_tkeep", m_if.tkeep, 0);
        chk("reset_tlast", m_if.tlast, 0);
        chk("reset_tdata", m_if.tdata, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Table pass 0 with m_tready high (plus one-cycle latency), pass 1 with random ready.
        for (int p = 0; p < 2; p++) begin
            rand_mode = (p == 1);
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].has) push(vecs[i].ed, vecs[i].ek, vecs[i].el);
                send(vecs[i].d, vecs[i].k, vecs[i].l, vecs[i].o);
                if (p == 0) begin
                    chk("lat_valid", m_if.tvalid, vecs[i].has);
                    if (vecs[i].has)
                        chk("lat_data", m_if.tdata & kmask(vecs[i].ek), vecs[i].ed & kmask(vecs[i].ek));
                end
            end
            drain();
            rand_mode = 1'b0;
            @(posedge aclk);
            #1;
            m_if.tready = 1'b1;
        end

        // Backpressure: m_tready low for 5 cycles mid-stream.
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    push(32'hC0DE0000 + 32'(b), 4'hF, b == 3);
                    send(32'hC0DE0000 + 32'(b), 4'hF, b == 3, 2'd0);
                end
            end
            begin
                repeat (2) @(posedge aclk);
                #1 m_if.tready = 1'b0;
                repeat (2) @(posedge aclk);
                @(negedge aclk);
                chk("bp_s_tready", s_if.tready, 0);
                chk("bp_m_tvalid", m_if.tvalid, 1);
                repeat (3) @(posedge aclk);
                #1 m_if.tready = 1'b1;
            end
        join
        drain();

        // Empty packet: nothing emitted, input ready again straight away.
        send(32'h87654321, 4'h0, 1'b1, 2'd2 ^ 2'd2);
        chk("zero_pkt_valid", m_if.tvalid, 0);
        chk("zero_pkt_ready", s_if.tready, 1);

        // Reset mid-packet with 6 bytes buffered, then a clean packet with its own offset.
        m_if.tready = 1'b0;
        send(32'h01020304, 4'hF, 1'b0, 2'd2);
        @(posedge aclk);
        #1;
        chk("pre_reset_valid", m_if.tvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("reset_async_valid", m_if.tvalid, 0);
        chk("reset_async_keep", m_if.tkeep, 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        m_if.tready = 1'b1;
        push(32'h00112233, 4'h7, 1'b0);
        push(32'h44000000, 4'h8, 1'b1);
        send(32'h11223344, 4'hF, 1'b1, 2'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
